// File: rtl/digit_streamer.sv
// Streams an 8-digit BCD value (with optional minus sign) to a display controller,
// one (pos, dig) write per cycle, blanking leading zeros and flagging malformed frames.
module digit_streamer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        neg,
  output logic [3:0]  dig,
  output logic [3:0]  pos,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned NIB = 8;
  localparam int unsigned NW  = 4;
  localparam int unsigned CW  = 3;

  localparam logic [NW-1:0] GLYPH_MINUS = 4'hA;
  localparam logic [NW-1:0] GLYPH_ERR   = 4'hE;
  localparam logic [NW-1:0] GLYPH_BLANK = 4'hF;

  typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

  state_t          state_q;
  logic [31:0]     val_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   msd_q;
  logic            ferr_q;
  logic [NW-1:0]   dig_q;
  logic [NW-1:0]   pos_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic [CW-1:0]   msd_c;
  logic            bad_c;
  logic [NW-1:0]   nib_c;
  logic [NW-1:0]   dig_c;

  // Frame analysis: highest nonzero nibble and malformed-frame detection.
  always_comb begin
    msd_c = '0;
    bad_c = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (val_q[NW*i +: NW] != '0)      msd_c = CW'(i);
      if (val_q[NW*i +: NW] > 4'd9)     bad_c = 1'b1;
    end
    if (neg_q && (val_q[31:28] != '0))  bad_c = 1'b1;
  end

  // Glyph for the current counter position: digit, minus sign just above msd, else blank.
  always_comb begin
    nib_c = val_q[{cnt_q, 2'b00} +: NW];
    dig_c = GLYPH_BLANK;
    if (cnt_q <= msd_q) begin
      dig_c = nib_c;
    end else if (neg_q && ({1'b0, cnt_q} == ({1'b0, msd_q} + 4'd1))) begin
      dig_c = GLYPH_MINUS;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      msd_q   <= '0;
      ferr_q  <= 1'b0;
      dig_q   <= GLYPH_BLANK;
      pos_q   <= 4'hF;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dig_q  <= GLYPH_BLANK;
      pos_q  <= 4'hF;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            val_q   <= value;
            neg_q   <= neg;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          msd_q   <= msd_c;
          ferr_q  <= bad_c;
          cnt_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          pos_q <= {1'b0, cnt_q};
          dig_q <= ferr_q ? GLYPH_ERR : dig_c;
          err_q <= ferr_q;
          // Counter parks at 7 on exit; SCAN re-zeroes it for the next frame.
          if (cnt_q == CW'(NIB - 1)) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dig  = dig_q;
  assign pos  = pos_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_digit_streamer.sv
// Directed bench for digit_streamer: inputs driven and outputs sampled on the falling edge.
module tb_digit_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] value;
  logic        neg;
  logic [3:0]  dig;
  logic [3:0]  pos;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  digit_streamer dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .value (value),
    .neg   (neg),
    .dig   (dig),
    .pos   (pos),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One full frame; exp_digs nibble k is the glyph expected at pos k.
  // poke_k >= 0 pulses a conflicting load during that SEND cycle.
  task automatic run_frame(input string name, input logic [31:0] v, input logic n,
                           input logic [31:0] exp_digs, input logic exp_err, input int poke_k);
    logic [31:0] ed;
    value = v; neg = n; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    chk({name, "_accept_busy"}, 32'(busy), 32'd1);
    chk({name, "_accept_errclr"}, 32'(err), 32'd0);
    chk({name, "_accept_pos"}, 32'(pos), 32'hF);
    @(negedge clock);
    chk({name, "_scan_busy"}, 32'(busy), 32'd1);
    chk({name, "_scan_pos"}, 32'(pos), 32'hF);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      load = 1'b0;
      ed = 32'(exp_digs[4*k +: 4]);
      chk($sformatf("%s_pos%0d", name, k), 32'(pos), 32'(k));
      chk($sformatf("%s_dig%0d", name, k), 32'(dig), ed);
      chk($sformatf("%s_busy%0d", name, k), 32'(busy), 32'd1);
      chk($sformatf("%s_err%0d", name, k), 32'(err), 32'(exp_err));
      chk($sformatf("%s_nodone%0d", name, k), 32'(done), 32'd0);
      if (k == poke_k) begin
        value = 32'h99999999; neg = 1'b1; load = 1'b1;
      end
    end
    @(negedge clock);
    load = 1'b0;
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_done_pos"}, 32'(pos), 32'hF);
    chk({name, "_done_dig"}, 32'(dig), 32'hF);
    chk({name, "_done_busy"}, 32'(busy), 32'd0);
    @(negedge clock);
    chk({name, "_idle_done"}, 32'(done), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int first_done;
    int second_done;
    int ndone;

    reset = 1'b1; load = 1'b0; value = '0; neg = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_pos", 32'(pos), 32'hF);
    chk("rst_dig", 32'(dig), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_pos", 32'(pos), 32'hF);

    run_frame("f123",  32'h00000123, 1'b0, 32'hFFFFF123, 1'b0, -1);
    run_frame("fneg45", 32'h00000045, 1'b1, 32'hFFFFFA45, 1'b0, -1);
    run_frame("fneg0", 32'h00000000, 1'b1, 32'hFFFFFFA0, 1'b0, -1);
    run_frame("fzero", 32'h00000000, 1'b0, 32'hFFFFFFF0, 1'b0, -1);
    run_frame("ferrA", 32'h0000A001, 1'b0, 32'hEEEEEEEE, 1'b1, -1);
    run_frame("ferrN", 32'h10000000, 1'b1, 32'hEEEEEEEE, 1'b1, -1);
    run_frame("fclr",  32'h00000123, 1'b0, 32'hFFFFF123, 1'b0, -1);
    run_frame("fpoke", 32'h00000123, 1'b0, 32'hFFFFF123, 1'b0, 3);
    run_frame("ffull", 32'h98765432, 1'b0, 32'h98765432, 1'b0, -1);
    run_frame("fneg7", 32'h01234567, 1'b1, 32'hA1234567, 1'b0, -1);

    // Load held high: frames restart every 11 cycles.
    value = 32'h00000007; neg = 1'b0; load = 1'b1;
    first_done = -1; second_done = -1; ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) begin
        if (ndone == 0) first_done = i;
        else if (ndone == 1) second_done = i;
        ndone++;
      end
    end
    load = 1'b0;
    chk("held_first_done", 32'(first_done), 32'd10);
    chk("held_second_done", 32'(second_done), 32'd21);
    chk("held_ndone", 32'(ndone), 32'd2);
    repeat (15) @(negedge clock);
    chk("held_drain_busy", 32'(busy), 32'd0);

    // Reset in the 4th SEND cycle abandons the frame.
    value = 32'h00000123; neg = 1'b0; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (4) @(negedge clock);
    chk("rstmid_pos2", 32'(pos), 32'd2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstmid_pos", 32'(pos), 32'hF);
    chk("rstmid_dig", 32'(dig), 32'hF);
    chk("rstmid_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    chk("rstmid_nodone", 32'(ndone), 32'd0);

    // Load coincident with reset is discarded.
    reset = 1'b1; load = 1'b1;
    @(negedge clock);
    reset = 1'b0; load = 1'b0;
    chk("rstload_busy", 32'(busy), 32'd0);
    @(negedge clock);
    chk("rstload_busy2", 32'(busy), 32'd0);
    chk("rstload_pos", 32'(pos), 32'hF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
